// File: rtl/sparc_ifu_pcrewind46_pkg.sv
// ---------------------------------------------------------------------------
// sparc_ifu_pcrewind46_pkg
// Shared IFU definitions for the PC rewind engine and its decrementer.
//   PC_W    : word-granular PC width (PC[47:2])
//   CNT_W   : rewind count width (up to 2^CNT_W-1 beats per request)
//   rewind_state_e : engine state encoding (IDLE=0, EMIT=1)
// ---------------------------------------------------------------------------
package sparc_ifu_pcrewind46_pkg;

  localparam int PC_W  = 46;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rewind_state_e;

endpackage

// File: rtl/sparc_ifu_pcrewind46_decr.sv
// ---------------------------------------------------------------------------
// sparc_ifu_decr46
// Combinational modulo-2^PC_W decrement of a word PC, the mirror image of
// the fetch-path +1 incrementer.
// Ports:
//   a     : PC to decrement
//   a_dec : a - 1 (wraps 0 -> all-ones)
//   ufl   : top bit went 1 -> 0 on this step
//   wrap  : step was from 0 to all-ones
// ---------------------------------------------------------------------------
module sparc_ifu_decr46
  import sparc_ifu_pcrewind46_pkg::*;
(
  input  logic [PC_W-1:0] a,
  output logic [PC_W-1:0] a_dec,
  output logic            ufl,
  output logic            wrap
);

  assign a_dec = a - PC_W'(1);

  // Underflow is judged on the top bit only, matching how the incrementer
  // reports overflow when bit45 goes 0 -> 1.
  assign ufl  = a[PC_W-1] & ~a_dec[PC_W-1];
  assign wrap = (a == '0);

endmodule

// File: rtl/sparc_ifu_pcrewind46.sv
// ---------------------------------------------------------------------------
// sparc_ifu_pcrewind46
// Sequential PC rewind engine. Accepts {req_pc, req_cnt} and emits req_cnt
// successively decremented PCs (req_pc-1, req_pc-2, ...) over a valid/ready
// stream, one beat per cycle when the consumer is ready.
// Ports:
//   clk, rst_l          : clock, synchronous active-low reset
//   req_vld/req_rdy     : request handshake; req_pc, req_cnt request payload
//   abort               : synchronous flush of an in-flight rewind
//   out_vld/out_rdy     : beat handshake
//   out_pc              : decremented PC for this beat
//   out_last            : final beat of the request
//   out_ufl, out_wrap   : per-beat bit45 underflow / 0->all-ones wrap flags
//   busy                : engine is emitting
// ---------------------------------------------------------------------------
module sparc_ifu_pcrewind46
  import sparc_ifu_pcrewind46_pkg::*;
(
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [PC_W-1:0]  req_pc,
  input  logic [CNT_W-1:0] req_cnt,
  input  logic             abort,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_last,
  output logic             out_ufl,
  output logic             out_wrap,
  output logic             busy
);

  rewind_state_e    state, state_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic [PC_W-1:0]  pc_n;
  logic             vld_n, last_n, ufl_n, wrap_n;

  logic [PC_W-1:0]  dec_in, dec_out;
  logic             dec_ufl, dec_wrap;
  logic             accept;

  // No same-cycle re-accept: req_rdy depends on the registered state only,
  // so a request is taken one cycle after the last beat hands off.
  assign req_rdy = rst_l & ~abort & (state == IDLE);
  assign accept  = req_vld & req_rdy & (req_cnt != '0);
  assign busy    = (state == EMIT);

  // A single decrementer serves both the first step (from req_pc) and every
  // following step (from the beat currently on the output).
  assign dec_in = (state == IDLE) ? req_pc : out_pc;

  sparc_ifu_decr46 u_decr (
    .a     (dec_in),
    .a_dec (dec_out),
    .ufl   (dec_ufl),
    .wrap  (dec_wrap)
  );

  // Next-state and next-output logic; every output is registered so beats
  // stay stable under backpressure without extra holding logic.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    pc_n        = out_pc;
    vld_n       = out_vld;
    last_n      = out_last;
    ufl_n       = out_ufl;
    wrap_n      = out_wrap;

    if (abort) begin
      state_n     = IDLE;
      remaining_n = '0;
      vld_n       = 1'b0;
      last_n      = 1'b0;
      ufl_n       = 1'b0;
      wrap_n      = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_n     = EMIT;
            remaining_n = req_cnt;
            pc_n        = dec_out;
            vld_n       = 1'b1;
            last_n      = (req_cnt == CNT_W'(1));
            ufl_n       = dec_ufl;
            wrap_n      = dec_wrap;
          end
        end
        EMIT: begin
          if (out_rdy) begin
            if (out_last) begin
              state_n     = IDLE;
              remaining_n = '0;
              vld_n       = 1'b0;
              last_n      = 1'b0;
              ufl_n       = 1'b0;
              wrap_n      = 1'b0;
            end else begin
              remaining_n = remaining - CNT_W'(1);
              pc_n        = dec_out;
              last_n      = (remaining == CNT_W'(2));
              ufl_n       = dec_ufl;
              wrap_n      = dec_wrap;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers; reset also clears the PC, which abort keeps.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= IDLE;
      remaining <= '0;
      out_pc    <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_ufl   <= 1'b0;
      out_wrap  <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      out_pc    <= pc_n;
      out_vld   <= vld_n;
      out_last  <= last_n;
      out_ufl   <= ufl_n;
      out_wrap  <= wrap_n;
    end
  end

endmodule
